// File: rtl/halve_pkg.sv
// Shared types and constants for the halving stream decoder.
package halve_pkg;

    localparam int unsigned HALVE_WIDTH = 8;
    localparam int unsigned HALVE_CNT_W = 16;

    localparam logic [HALVE_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef struct packed {
        logic [HALVE_WIDTH-1:0] data;
        logic                   err;
    } halve_entry_t;

endpackage

// File: rtl/halve_fifo.sv
// Small synchronous FIFO holding decoded entries; push is ignored when full,
// pop is ignored when empty.
module halve_fifo
    import halve_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = halve_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t wr_data,
    input  logic   pop,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the top masks the head while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/halve_stream.sv
// Recovers original values from a doubled-word stream (out = in >> 1),
// flagging and counting odd codes that a doubler could never produce.
module halve_stream
    import halve_pkg::*;
#(
    parameter int unsigned WIDTH = HALVE_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = HALVE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX =
        (CNT_W == HALVE_CNT_W) ? CNT_W'(ERR_CNT_MAX) : '1;

    entry_t           wr_entry;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_entry.data = {1'b0, in_data[WIDTH-1:1]};
    assign wr_entry.err  = in_data[0];

    halve_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign out_data  = empty ? '0 : head.data;
    assign out_err   = empty ? 1'b0 : head.err;
    assign err_count = err_count_q;

    always_comb begin
        err_count_d = err_count_q;
        if (push && in_data[0] && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

endmodule
